regfile_sequencer: RTL and testbench
====================================

Name: regfile_sequencer

Overview:
- Sequences one register-file transaction per request over the single-ported 32x32 register file: read source A, read source B, optional write-back of destination.
- Drives the file's REG_SEL, REG_SRC0..3, N_OE, N_WE and IN_DATA.
- Captures read data into operand registers.
- Sits between the instruction decode/execute control and the register file.

Parameters:
- DATA_W, 32, register data width.
- ADDR_W, 5, register address width (32 registers).

Ports:
- CLK  in  1  clock, rising edge.
- N_RST  in  1  reset, synchronous, active-high.
- REQ  in  1  start transaction; sampled only in IDLE.
- RS_A  in  ADDR_W  source A address.
- RS_B  in  ADDR_W  source B address.
- RD  in  ADDR_W  write-back address.
- WB_EN  in  1  perform write-back this transaction.
- WB_DATA  in  DATA_W  write-back value.
- RF_OUT  in  DATA_W  register file OUT_DATA.
- REG_SEL  out  2  register file address-mux select.
- REG_SRC0  out  ADDR_W  latched RS_A.
- REG_SRC1  out  ADDR_W  latched RS_B.
- REG_SRC2  out  ADDR_W  latched RD.
- REG_SRC3  out  ADDR_W  constant 0.
- RF_IN  out  DATA_W  latched WB_DATA, to register file IN_DATA.
- N_OE  out  1  register file output enable, active-low.
- N_WE  out  1  register file write enable, active-low.
- BUSY  out  1  high in any state except IDLE.
- DONE  out  1  one-cycle pulse; OP_A/OP_B valid.
- OP_A  out  DATA_W  source A value.
- OP_B  out  DATA_W  source B value.

Behaviour:
- Reset (N_RST=1 at edge): state IDLE; N_OE=N_WE=1; REG_SEL=0; DONE=0; OP_A=OP_B=RF_IN=0; REG_SRC0..2=0. Overrides any in-flight transaction; no write is issued in the cycle after reset.
- All outputs are registered. N_OE and N_WE are never both 0.
- State machine:
  - IDLE -> READ_A when REQ=1. RS_A, RS_B, RD, WB_EN and WB_DATA are latched on that edge.
  - READ_A: REG_SEL=00, N_OE=0. RF_OUT is captured into OP_A at the end of the cycle. Always -> READ_B.
  - READ_B: REG_SEL=01, N_OE=0. RF_OUT is captured into OP_B. Always -> WRITE.
  - WRITE: REG_SEL=10, N_OE=1, N_WE=0 iff latched WB_EN=1, DONE=1. Always -> IDLE.
- Latency: REQ accepted at edge k; DONE high in cycle k+3; next REQ accepted at edge k+4. Throughput is one transaction per 4 cycles.
- REQ while BUSY=1 is ignored, not queued. Input changes after acceptance have no effect.
- Reads precede the write. If RD equals RS_A or RS_B, the operands return the pre-write value.
- RS_A=RS_B is legal; both operands return the same value.
- OP_A and OP_B hold their values until the next transaction's READ_A/READ_B captures.

Optional Feature:
- Macro: RF_ZERO_REG_EN.
- Defined:
  - Address 0 reads as zero: OP_A/OP_B are forced to 0 when the latched address is 0, regardless of RF_OUT. N_OE is still asserted, keeping timing fixed.
  - Write-back to RD=0 is suppressed: N_WE stays 1. DONE still pulses.
- Undefined: register 0 is an ordinary register.

Decomposition:
- Package rf_seq_pkg:
  - state enum {IDLE, READ_A, READ_B, WRITE};
  - REG_SEL constants SEL_SRC_A=2'b00, SEL_SRC_B=2'b01, SEL_DST=2'b10, SEL_ZERO=2'b11;
  - DATA_W and ADDR_W defaults.
- No sub-module; a single FSM plus capture registers is natural.
- FORMAL block asserts:
  - N_WE || N_OE at all times;
  - DONE implies state WRITE;
  - REQ outside IDLE causes no change to the latched addresses.

Test Plan:
- Reset then idle: after N_RST, N_OE=1, N_WE=1, BUSY=0, DONE=0, OP_A=OP_B=0 -> stays so with REQ=0 for 10 cycles.
- Write then read: REQ with RD=5, WB_EN=1, WB_DATA=0xDEADBEEF -> N_WE=0 one cycle with REG_SEL=10, REG_SRC2=5. Then REQ with RS_A=5, RS_B=5 -> DONE at k+3, OP_A=OP_B=0xDEADBEEF.
- Read-before-write: r3=0x11; REQ with RS_A=3, RD=3, WB_DATA=0x22, WB_EN=1 -> OP_A=0x11; next read of r3 -> 0x22.
- Busy ignore: REQ held high 8 cycles with RS_A changing each cycle -> exactly two transactions (accepted at k and k+4), each using the RS_A present at its acceptance edge.
- Reset mid-op: assert N_RST during READ_B -> next cycle IDLE, N_OE=1, N_WE=1, no write observed, DONE never pulses.
- RF_ZERO_REG_EN: model returns 0xFFFFFFFF for r0; RS_A=0, RD=0, WB_EN=1 -> OP_A=0, N_WE stays 1. Without the macro -> OP_A=0xFFFFFFFF, N_WE pulses.

Source files
------------

// File: rtl/regfile_sequencer_pkg.sv
// rtl/regfile_sequencer_pkg.sv - shared types and constants for the register-file sequencer
package rf_seq_pkg;

  // Default widths: 32 registers of 32 bits
  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;

  // Sequencer states: one transaction walks IDLE -> READ_A -> READ_B -> WRITE -> IDLE
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    READ_A = 2'b01,
    READ_B = 2'b10,
    WRITE  = 2'b11
  } state_e;

  // Register-file address-mux select codes (REG_SEL)
  localparam logic [1:0] SEL_SRC_A = 2'b00;
  localparam logic [1:0] SEL_SRC_B = 2'b01;
  localparam logic [1:0] SEL_DST   = 2'b10;
  localparam logic [1:0] SEL_ZERO  = 2'b11;

endpackage

// File: rtl/regfile_sequencer_if.sv
// rtl/regfile_sequencer_if.sv - request, operand and register-file signals of the sequencer
interface regfile_sequencer_if
  import rf_seq_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
) ();

  // Request side (decode/execute control)
  logic              REQ;
  logic [ADDR_W-1:0] RS_A;
  logic [ADDR_W-1:0] RS_B;
  logic [ADDR_W-1:0] RD;
  logic              WB_EN;
  logic [DATA_W-1:0] WB_DATA;
  logic              BUSY;
  logic              DONE;
  logic [DATA_W-1:0] OP_A;
  logic [DATA_W-1:0] OP_B;

  // Register-file side
  logic [DATA_W-1:0] RF_OUT;
  logic [1:0]        REG_SEL;
  logic [ADDR_W-1:0] REG_SRC0;
  logic [ADDR_W-1:0] REG_SRC1;
  logic [ADDR_W-1:0] REG_SRC2;
  logic [ADDR_W-1:0] REG_SRC3;
  logic [DATA_W-1:0] RF_IN;
  logic              N_OE;
  logic              N_WE;

  // Environment view: issues requests and models the register file
  modport master (
    output REQ, RS_A, RS_B, RD, WB_EN, WB_DATA, RF_OUT,
    input  BUSY, DONE, OP_A, OP_B,
    input  REG_SEL, REG_SRC0, REG_SRC1, REG_SRC2, REG_SRC3, RF_IN, N_OE, N_WE
  );

  // Sequencer view
  modport slave (
    input  REQ, RS_A, RS_B, RD, WB_EN, WB_DATA, RF_OUT,
    output BUSY, DONE, OP_A, OP_B,
    output REG_SEL, REG_SRC0, REG_SRC1, REG_SRC2, REG_SRC3, RF_IN, N_OE, N_WE
  );

endinterface

// File: rtl/regfile_sequencer.sv
// rtl/regfile_sequencer.sv - read A, read B, optional write-back sequencer (option: RF_ZERO_REG_EN)
module regfile_sequencer
  import rf_seq_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic                CLK,
  input  logic                N_RST,
  regfile_sequencer_if.slave  bus
);

`ifdef RF_ZERO_REG_EN
  // Register 0 is hard-wired to zero: reads return 0, writes are dropped
  localparam bit ZeroReg = 1'b1;
`else
  // Register 0 behaves like any other register
  localparam bit ZeroReg = 1'b0;
`endif

  state_e            state_q;
  logic [1:0]        reg_sel_q;
  logic [ADDR_W-1:0] src0_q;
  logic [ADDR_W-1:0] src1_q;
  logic [ADDR_W-1:0] src2_q;
  logic [DATA_W-1:0] rf_in_q;
  logic              wb_go_q;
  logic              n_oe_q;
  logic              n_we_q;
  logic              done_q;
  logic [DATA_W-1:0] op_a_q;
  logic [DATA_W-1:0] op_b_q;

  // Sequencer FSM; every output is a register updated here
  always_ff @(posedge CLK) begin
    if (N_RST) begin
      state_q   <= IDLE;
      reg_sel_q <= SEL_SRC_A;
      src0_q    <= '0;
      src1_q    <= '0;
      src2_q    <= '0;
      rf_in_q   <= '0;
      wb_go_q   <= 1'b0;
      n_oe_q    <= 1'b1;
      n_we_q    <= 1'b1;
      done_q    <= 1'b0;
      op_a_q    <= '0;
      op_b_q    <= '0;
    end else begin
      // Write strobe and DONE are single-cycle; default them off
      done_q <= 1'b0;
      n_we_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (bus.REQ) begin
            // Freeze the whole request so later input changes cannot leak in
            src0_q    <= bus.RS_A;
            src1_q    <= bus.RS_B;
            src2_q    <= bus.RD;
            rf_in_q   <= bus.WB_DATA;
            wb_go_q   <= bus.WB_EN && !(ZeroReg && (bus.RD == '0));
            reg_sel_q <= SEL_SRC_A;
            n_oe_q    <= 1'b0;
            state_q   <= READ_A;
          end
        end
        READ_A: begin
          op_a_q    <= (ZeroReg && (src0_q == '0)) ? '0 : bus.RF_OUT;
          reg_sel_q <= SEL_SRC_B;
          n_oe_q    <= 1'b0;
          state_q   <= READ_B;
        end
        READ_B: begin
          // Output enable drops in the same edge the write strobe may rise,
          // so the two are never low together
          op_b_q    <= (ZeroReg && (src1_q == '0)) ? '0 : bus.RF_OUT;
          reg_sel_q <= SEL_DST;
          n_oe_q    <= 1'b1;
          n_we_q    <= !wb_go_q;
          done_q    <= 1'b1;
          state_q   <= WRITE;
        end
        WRITE: begin
          reg_sel_q <= SEL_SRC_A;
          n_oe_q    <= 1'b1;
          state_q   <= IDLE;
        end
        default: begin
          n_oe_q  <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.BUSY     = (state_q != IDLE);
  assign bus.DONE     = done_q;
  assign bus.OP_A     = op_a_q;
  assign bus.OP_B     = op_b_q;
  assign bus.REG_SEL  = reg_sel_q;
  assign bus.REG_SRC0 = src0_q;
  assign bus.REG_SRC1 = src1_q;
  assign bus.REG_SRC2 = src2_q;
  assign bus.REG_SRC3 = '0;
  assign bus.RF_IN    = rf_in_q;
  assign bus.N_OE     = n_oe_q;
  assign bus.N_WE     = n_we_q;

`ifdef FORMAL
  // Output enable and write enable are never both active
  a_oe_we_excl: assert property (@(posedge CLK) n_we_q || n_oe_q);

  // DONE is only ever seen in the write phase
  a_done_write: assert property (@(posedge CLK) done_q |-> (state_q == WRITE));

  // A request arriving while busy leaves the latched addresses alone
  a_req_busy_ignored: assert property (@(posedge CLK) disable iff (N_RST)
    (bus.REQ && (state_q != IDLE)) |=>
      ($stable(src0_q) && $stable(src1_q) && $stable(src2_q)));
`endif

endmodule

// File: tb/tb_regfile_sequencer.sv
// tb/tb_regfile_sequencer.sv - randomized bench with register-file model and reference model
module tb_regfile_sequencer;
  import rf_seq_pkg::*;

`ifdef RF_ZERO_REG_EN
  localparam bit ZERO = 1'b1;
`else
  localparam bit ZERO = 1'b0;
`endif

  logic clk = 1'b0;
  logic n_rst;
  logic rf_init;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_wr    = 0;
  int   n_done  = 0;

  always #5 clk = ~clk;

  regfile_sequencer_if bus ();

  regfile_sequencer dut (
    .CLK   (clk),
    .N_RST (n_rst),
    .bus   (bus.slave)
  );

  // Register-file model: combinational read through the address mux, write on clock edge
  logic [31:0] rf_mem [32];
  logic [4:0]  rf_addr;

  function automatic logic [31:0] init_word(input int i);
    return (i == 0) ? 32'hFFFF_FFFF : (32'h1000_0000 + 32'(i) * 32'h0001_0101);
  endfunction

  always @(posedge clk) begin
    if (rf_init) begin
      for (int i = 0; i < 32; i++) rf_mem[i] <= init_word(i);
    end else if (!bus.N_WE) begin
      rf_mem[bus.REG_SRC2] <= bus.RF_IN;
    end
  end

  assign rf_addr = (bus.REG_SEL == 2'b00) ? bus.REG_SRC0 :
                   (bus.REG_SEL == 2'b01) ? bus.REG_SRC1 :
                   (bus.REG_SEL == 2'b10) ? bus.REG_SRC2 : bus.REG_SRC3;
  assign bus.RF_OUT = bus.N_OE ? 32'h0 : rf_mem[rf_addr];

  // Event counters sampled away from the active edge
  always @(negedge clk) begin
    if (!bus.N_WE) n_wr++;
    if (bus.DONE)  n_done++;
  end

  // Reference model: architectural register contents
  logic [31:0] ref_mem [32];

  function automatic logic [31:0] ref_read(input logic [4:0] a);
    if (ZERO && a == 5'd0) return 32'h0;
    return ref_mem[a];
  endfunction

  function automatic bit ref_writes(input logic [4:0] d, input logic we);
    return we && !(ZERO && d == 5'd0);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive_idle_inputs();
    bus.REQ     = 1'b0;
    bus.RS_A    = 5'($urandom);
    bus.RS_B    = 5'($urandom);
    bus.RD      = 5'($urandom);
    bus.WB_EN   = 1'($urandom);
    bus.WB_DATA = $urandom;
  endtask

  // One full transaction, checked phase by phase against the reference model
  task automatic run_txn(input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                         input logic we, input logic [31:0] data);
    logic [31:0] ea, eb;
    bit          ew;
    ea = ref_read(a);
    eb = ref_read(b);
    ew = ref_writes(d, we);
    @(negedge clk);
    check("idle_before", 32'(bus.BUSY), 32'd0);
    bus.REQ = 1'b1; bus.RS_A = a; bus.RS_B = b; bus.RD = d; bus.WB_EN = we; bus.WB_DATA = data;
    @(negedge clk);
    drive_idle_inputs();
    check("ra_sel",  32'(bus.REG_SEL), 32'd0);
    check("ra_noe",  32'(bus.N_OE), 32'd0);
    check("ra_src0", 32'(bus.REG_SRC0), 32'(a));
    check("ra_busy", 32'(bus.BUSY), 32'd1);
    @(negedge clk);
    check("rb_sel",  32'(bus.REG_SEL), 32'd1);
    check("rb_noe",  32'(bus.N_OE), 32'd0);
    check("rb_src1", 32'(bus.REG_SRC1), 32'(b));
    check("rb_opa",  bus.OP_A, ea);
    @(negedge clk);
    check("wr_done", 32'(bus.DONE), 32'd1);
    check("wr_sel",  32'(bus.REG_SEL), 32'd2);
    check("wr_noe",  32'(bus.N_OE), 32'd1);
    check("wr_nwe",  32'(bus.N_WE), 32'(!ew));
    check("wr_opb",  bus.OP_B, eb);
    if (ew) begin
      check("wr_src2", 32'(bus.REG_SRC2), 32'(d));
      check("wr_data", bus.RF_IN, data);
      ref_mem[d] = data;
    end
    @(negedge clk);
    check("end_busy", 32'(bus.BUSY), 32'd0);
    check("end_done", 32'(bus.DONE), 32'd0);
    check("end_nwe",  32'(bus.N_WE), 32'd1);
    check("end_opa",  bus.OP_A, ea);
    check("end_opb",  bus.OP_B, eb);
  endtask

  initial begin
    int          wr0, done0;
    logic [4:0]  ra [8];
    logic [31:0] ea;

    n_rst = 1'b1;
    rf_init = 1'b1;
    drive_idle_inputs();
    repeat (2) @(negedge clk);
    n_rst = 1'b0;
    rf_init = 1'b0;
    for (int i = 0; i < 32; i++) ref_mem[i] = init_word(i);

    // Reset, then idle with no requests
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive_idle_inputs();
      check("rst_noe",  32'(bus.N_OE), 32'd1);
      check("rst_nwe",  32'(bus.N_WE), 32'd1);
      check("rst_busy", 32'(bus.BUSY), 32'd0);
      check("rst_done", 32'(bus.DONE), 32'd0);
      check("rst_opa",  bus.OP_A, 32'd0);
      check("rst_opb",  bus.OP_B, 32'd0);
    end

    // Register 0 behaviour, with or without the zero-register option
    wr0 = n_wr;
    run_txn(5'd0, 5'd1, 5'd0, 1'b1, 32'h0000_1234);
    check("zero_opa", bus.OP_A, ZERO ? 32'h0 : 32'hFFFF_FFFF);
    check("zero_wr",  32'(n_wr - wr0), ZERO ? 32'd0 : 32'd1);

    // Write then read back through both ports
    run_txn(5'd1, 5'd2, 5'd5, 1'b1, 32'hDEAD_BEEF);
    run_txn(5'd5, 5'd5, 5'd9, 1'b0, 32'h0);
    check("wrrd_opa", bus.OP_A, 32'hDEAD_BEEF);
    check("wrrd_opb", bus.OP_B, 32'hDEAD_BEEF);

    // Reads see the pre-write value when RD aliases a source
    run_txn(5'd4, 5'd4, 5'd3, 1'b1, 32'h0000_0011);
    run_txn(5'd3, 5'd6, 5'd3, 1'b1, 32'h0000_0022);
    check("rbw_old", bus.OP_A, 32'h0000_0011);
    run_txn(5'd3, 5'd3, 5'd7, 1'b0, 32'h0);
    check("rbw_new", bus.OP_A, 32'h0000_0022);

    // Requests held high while busy: only acceptances at k and k+4
    done0 = n_done;
    for (int i = 0; i < 8; i++) ra[i] = 5'($urandom);
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.REQ = 1'b1; bus.RS_A = ra[i]; bus.RS_B = 5'd2; bus.RD = 5'd0; bus.WB_EN = 1'b0;
      @(negedge clk);
      if (i == 0) check("busy_src_k",  32'(bus.REG_SRC0), 32'(ra[0]));
      if (i == 4) check("busy_src_k4", 32'(bus.REG_SRC0), 32'(ra[4]));
    end
    bus.REQ = 1'b0;
    repeat (4) @(negedge clk);
    check("busy_ndone", 32'(n_done - done0), 32'd2);
    check("busy_opa",   bus.OP_A, ref_read(ra[4]));
    check("busy_opb",   bus.OP_B, ref_read(5'd2));

    // Randomized transactions
    for (int t = 0; t < 24; t++) begin
      run_txn(5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), $urandom);
    end

    // Reset during READ_B cancels the pending write and DONE
    wr0 = n_wr;
    done0 = n_done;
    @(negedge clk);
    bus.REQ = 1'b1; bus.RS_A = 5'd8; bus.RS_B = 5'd9; bus.RD = 5'd10; bus.WB_EN = 1'b1;
    bus.WB_DATA = 32'hCAFE_F00D;
    @(negedge clk);
    bus.REQ = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    n_rst = 1'b0;
    check("mid_busy", 32'(bus.BUSY), 32'd0);
    check("mid_noe",  32'(bus.N_OE), 32'd1);
    check("mid_nwe",  32'(bus.N_WE), 32'd1);
    check("mid_done", 32'(bus.DONE), 32'd0);
    check("mid_opa",  bus.OP_A, 32'd0);
    check("mid_src0", 32'(bus.REG_SRC0), 32'd0);
    repeat (4) @(negedge clk);
    check("mid_nwr",   32'(n_wr - wr0), 32'd0);
    check("mid_ndone", 32'(n_done - done0), 32'd0);

    // Register 10 must still hold its old value
    ea = ref_read(5'd10);
    run_txn(5'd10, 5'd8, 5'd11, 1'b0, 32'h0);
    check("mid_r10", bus.OP_A, ea);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
